// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for the multi-slot alarm clock.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    localparam int MAX_H = 23;
    localparam int MAX_M = 59;

    function automatic logic bcd_valid(input bcd_time_t t);
        int h;
        int m;
        h = 10 * int'(t.h1) + int'(t.h0);
        m = 10 * int'(t.m1) + int'(t.m0);
        return (t.h0 <= 4'd9) && (t.m0 <= 4'd9) && (h <= MAX_H) && (m <= MAX_M);
    endfunction

    // Adds n (0..59) minutes; tens digit rebuilt by threshold compares, not division.
    function automatic bcd_time_t bcd_add_min(input bcd_time_t t, input int n);
        bcd_time_t r;
        int m;
        r = t;
        m = 10 * int'(t.m1) + int'(t.m0) + n;
        if (m > MAX_M) begin
            m = m - (MAX_M + 1);
            if (t.h1 == 2'd2 && t.h0 == 4'd3) begin
                r.h1 = 2'd0;
                r.h0 = 4'd0;
            end else if (t.h0 == 4'd9) begin
                r.h1 = t.h1 + 2'd1;
                r.h0 = 4'd0;
            end else begin
                r.h0 = t.h0 + 4'd1;
            end
        end
        r.m1 = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            if (m >= 10 * k) r.m1 = 4'(k);
        end
        r.m0 = 4'(m - 10 * int'(r.m1));
        return r;
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored alarm time, snooze target, ring-length counter and state.
module alarm_slot
    import alarm_clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tick,
    input  bcd_time_t next_hm,
    input  logic      next_sec_zero,
    input  bcd_time_t cur_hm,
    input  logic      al_on,
    input  logic      stop_al,
    input  logic      snooze,
    input  logic      ld,
    input  bcd_time_t ld_val,
    output logic      ringing
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_RINGING = RINGING;
    localparam logic [1:0] ST_SNOOZED = SNOOZED;

    logic [1:0] state_reg, state_next;
    bcd_time_t  al_reg, al_next;
    bcd_time_t  tgt_reg, tgt_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       at_alarm, at_target;

    // tick arrives already masked when a time load happens in the same cycle
    assign at_alarm  = tick && next_sec_zero && (next_hm == al_reg);
    assign at_target = tick && next_sec_zero && (next_hm == tgt_reg);
    assign ringing   = (state_reg == ST_RINGING);

    always_comb begin
        state_next = state_reg;
        al_next    = al_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;
        if (ld) al_next = ld_val;
        if (stop_al || !al_on) begin
            state_next = ST_IDLE;
        end else if (ld) begin
            state_next = ST_IDLE;
        end else if (state_reg == ST_RINGING && snooze) begin
            state_next = ST_SNOOZED;
            tgt_next   = bcd_add_min(cur_hm, SNOOZE_MIN);
            cnt_next   = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: if (at_alarm) begin
                    state_next = ST_RINGING;
                    cnt_next   = 8'd0;
                end
                ST_SNOOZED: if (at_target) begin
                    state_next = ST_RINGING;
                    cnt_next   = 8'd0;
                end
                ST_RINGING: if (tick) begin
                    if (cnt_reg == 8'(RING_SEC - 1)) state_next = ST_IDLE;
                    else cnt_next = cnt_reg + 8'd1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            al_reg    <= '0;
            tgt_reg   <= '0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            al_reg    <= al_next;
            tgt_reg   <= tgt_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/alarm_clock_multi.sv
// HH:MM:SS BCD clock with NUM_ALARMS independent alarm slots.
// Optional HOUR12_EN macro switches the hour display to 12 h with a pm flag.
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_time,
    input  logic                  ld_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [1:0]            h_in1,
    input  logic [3:0]            h_in0,
    input  logic [3:0]            m_in1,
    input  logic [3:0]            m_in0,
    input  logic [NUM_ALARMS-1:0] al_on,
    input  logic                  stop_al,
    input  logic                  snooze,
    output logic [1:0]            h_out1,
    output logic [3:0]            h_out0,
    output logic [3:0]            m_out1,
    output logic [3:0]            m_out0,
    output logic [3:0]            s_out1,
    output logic [3:0]            s_out0,
    output logic                  pm,
    output logic                  tick_1s,
    output logic                  alarm,
    output logic [AW-1:0]         alarm_id,
    output logic                  ld_err
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0]         pre_reg;
    bcd_time_t             hm_reg, inc_hm, in_hm;
    logic [3:0]            s1_reg, s0_reg, inc_s1, inc_s0;
    logic                  tick, in_valid, ld_time_ok;
    logic                  alarm_reg, ld_err_reg;
    logic [AW-1:0]         id_reg, id_next;
    logic [NUM_ALARMS-1:0] ringing;

    assign in_hm      = {h_in1, h_in0, m_in1, m_in0};
    assign in_valid   = bcd_valid(in_hm);
    assign ld_time_ok = ld_time && in_valid;
    assign tick       = (pre_reg == PW'(CLK_HZ - 1));

    // Per-digit BCD increment of the whole time of day.
    always_comb begin
        inc_hm = hm_reg;
        inc_s1 = s1_reg;
        inc_s0 = s0_reg + 4'd1;
        if (s0_reg == 4'd9) begin
            inc_s0 = 4'd0;
            inc_s1 = s1_reg + 4'd1;
            if (s1_reg == 4'd5) begin
                inc_s1    = 4'd0;
                inc_hm.m0 = hm_reg.m0 + 4'd1;
                if (hm_reg.m0 == 4'd9) begin
                    inc_hm.m0 = 4'd0;
                    inc_hm.m1 = hm_reg.m1 + 4'd1;
                    if (hm_reg.m1 == 4'd5) begin
                        inc_hm.m1 = 4'd0;
                        if (hm_reg.h1 == 2'd2 && hm_reg.h0 == 4'd3) begin
                            inc_hm.h1 = 2'd0;
                            inc_hm.h0 = 4'd0;
                        end else if (hm_reg.h0 == 4'd9) begin
                            inc_hm.h1 = hm_reg.h1 + 2'd1;
                            inc_hm.h0 = 4'd0;
                        end else begin
                            inc_hm.h0 = hm_reg.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
        alarm_slot #(
            .SNOOZE_MIN(SNOOZE_MIN),
            .RING_SEC  (RING_SEC)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick && !ld_time_ok),
            .next_hm      (inc_hm),
            .next_sec_zero((inc_s1 == 4'd0) && (inc_s0 == 4'd0)),
            .cur_hm       (hm_reg),
            .al_on        (al_on[gi]),
            .stop_al      (stop_al),
            .snooze       (snooze),
            .ld           (ld_alarm && in_valid && (alarm_sel == AW'(gi))),
            .ld_val       (in_hm),
            .ringing      (ringing[gi])
        );
    end

    always_comb begin
        id_next = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) id_next = AW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg    <= '0;
            hm_reg     <= '0;
            s1_reg     <= 4'd0;
            s0_reg     <= 4'd0;
            alarm_reg  <= 1'b0;
            id_reg     <= '0;
            ld_err_reg <= 1'b0;
        end else begin
            ld_err_reg <= (ld_time || ld_alarm) && !in_valid;
            alarm_reg  <= |ringing;
            id_reg     <= id_next;
            if (ld_time_ok) begin
                hm_reg  <= in_hm;
                s1_reg  <= 4'd0;
                s0_reg  <= 4'd0;
                pre_reg <= '0;
            end else if (tick) begin
                hm_reg  <= inc_hm;
                s1_reg  <= inc_s1;
                s0_reg  <= inc_s0;
                pre_reg <= '0;
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end
        end
    end

`ifdef HOUR12_EN
    // 00 -> 12, 13..23 -> 01..11; storage and comparisons stay 24 h.
    always_comb begin
        h_out1 = hm_reg.h1;
        h_out0 = hm_reg.h0;
        pm     = 1'b0;
        if (hm_reg.h1 == 2'd0 && hm_reg.h0 == 4'd0) begin
            h_out1 = 2'd1;
            h_out0 = 4'd2;
        end else if (hm_reg.h1 == 2'd1 && hm_reg.h0 >= 4'd2) begin
            pm = 1'b1;
            if (hm_reg.h0 >= 4'd3) begin
                h_out1 = 2'd0;
                h_out0 = hm_reg.h0 - 4'd2;
            end
        end else if (hm_reg.h1 == 2'd2) begin
            pm = 1'b1;
            if (hm_reg.h0 <= 4'd1) begin
                h_out1 = 2'd0;
                h_out0 = hm_reg.h0 + 4'd8;
            end else begin
                h_out1 = 2'd1;
                h_out0 = hm_reg.h0 - 4'd2;
            end
        end
    end
`else
    assign h_out1 = hm_reg.h1;
    assign h_out0 = hm_reg.h0;
    assign pm     = 1'b0;
`endif

    assign m_out1   = hm_reg.m1;
    assign m_out0   = hm_reg.m0;
    assign s_out1   = s1_reg;
    assign s_out0   = s0_reg;
    assign tick_1s  = tick;
    assign alarm    = alarm_reg;
    assign alarm_id = id_reg;
    assign ld_err   = ld_err_reg;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed plus randomized bench; reference model tracks time as seconds-of-day.
module tb_alarm_clock_multi;

    localparam int CLK_HZ = 4;
    localparam int NA     = 4;
    localparam int SNZ    = 5;
    localparam int RS     = 3;

    logic       clk = 1'b0;
    logic       reset, ld_time, ld_alarm, stop_al, snooze;
    logic [1:0] alarm_sel;
    logic [1:0] h_in1;
    logic [3:0] h_in0, m_in1, m_in0;
    logic [3:0] al_on;
    logic [1:0] h_out1;
    logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;
    logic       pm, tick_1s, alarm, ld_err;
    logic [1:0] alarm_id;

    alarm_clock_multi #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_SEC(RS)
    ) dut (
        .clk(clk), .reset(reset), .ld_time(ld_time), .ld_alarm(ld_alarm),
        .alarm_sel(alarm_sel), .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1),
        .m_in0(m_in0), .al_on(al_on), .stop_al(stop_al), .snooze(snooze),
        .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1), .m_out0(m_out0),
        .s_out1(s_out1), .s_out0(s_out0), .pm(pm), .tick_1s(tick_1s),
        .alarm(alarm), .alarm_id(alarm_id), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: m_sec is seconds since midnight, alarm times and snooze targets are
    // minutes since midnight, slot status 0 = idle, 1 = ringing, 2 = snoozed.
    int m_sec, m_pre, m_id;
    int m_al[NA], m_st[NA], m_tgt[NA], m_cnt[NA];
    bit m_alarm, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int h, hd, mm, ss;
        bit pmx;
        h   = m_sec / 3600;
        mm  = (m_sec / 60) % 60;
        ss  = m_sec % 60;
        hd  = h;
        pmx = 1'b0;
`ifdef HOUR12_EN
        hd  = (h % 12 == 0) ? 12 : h % 12;
        pmx = (h >= 12);
`endif
        chk("h_out1", 32'(h_out1), hd / 10);
        chk("h_out0", 32'(h_out0), hd % 10);
        chk("m_out1", 32'(m_out1), mm / 10);
        chk("m_out0", 32'(m_out0), mm % 10);
        chk("s_out1", 32'(s_out1), ss / 10);
        chk("s_out0", 32'(s_out0), ss % 10);
        chk("pm", 32'(pm), 32'(pmx));
        chk("tick_1s", 32'(tick_1s), 32'(m_pre == CLK_HZ - 1));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("alarm_id", 32'(alarm_id), m_id);
        chk("ld_err", 32'(ld_err), 32'(m_err));
    endtask

    task automatic step();
        int  h, m, post, cur_min, id;
        bit  valid, tick, ldt, mt, any, own;
        @(posedge clk);
        if (reset) begin
            m_sec = 0; m_pre = 0; m_id = 0; m_alarm = 0; m_err = 0;
            for (int i = 0; i < NA; i++) begin
                m_al[i] = 0; m_st[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            h = int'(h_in1) * 10 + int'(h_in0);
            m = int'(m_in1) * 10 + int'(m_in0);
            valid = (h_in0 <= 4'd9) && (m_in0 <= 4'd9) && (h <= 23) && (m <= 59);
            any = 0;
            id  = 0;
            for (int i = NA - 1; i >= 0; i--) begin
                if (m_st[i] == 1) begin any = 1; id = i; end
            end
            m_alarm = any;
            m_id    = id;
            m_err   = (ld_time || ld_alarm) && !valid;
            tick    = (m_pre == CLK_HZ - 1);
            ldt     = ld_time && valid;
            mt      = tick && !ldt;
            post    = (m_sec + 1) % 86400;
            cur_min = m_sec / 60;
            for (int i = 0; i < NA; i++) begin
                own = ld_alarm && valid && (int'(alarm_sel) == i);
                if (own) m_al[i] = h * 60 + m;
                if (stop_al || !al_on[i]) m_st[i] = 0;
                else if (own) m_st[i] = 0;
                else if (m_st[i] == 1 && snooze) begin
                    m_st[i] = 2; m_tgt[i] = (cur_min + SNZ) % 1440; m_cnt[i] = 0;
                end else if (mt) begin
                    if (m_st[i] == 0 && post % 60 == 0 && post / 60 == m_al[i]) begin
                        m_st[i] = 1; m_cnt[i] = 0;
                    end else if (m_st[i] == 2 && post % 60 == 0 && post / 60 == m_tgt[i]) begin
                        m_st[i] = 1; m_cnt[i] = 0;
                    end else if (m_st[i] == 1) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == RS) m_st[i] = 0;
                    end
                end
            end
            if (ldt) begin m_sec = (h * 60 + m) * 60; m_pre = 0; end
            else if (tick) begin m_sec = post; m_pre = 0; end
            else m_pre++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_hm(input int h, input int m);
        h_in1 = 2'(h / 10); h_in0 = 4'(h % 10);
        m_in1 = 4'(m / 10); m_in0 = 4'(m % 10);
    endtask

    task automatic load_time(input int h, input int m);
        set_hm(h, m); ld_time = 1'b1; step(); ld_time = 1'b0;
    endtask

    task automatic load_alarm(input int sel, input int h, input int m);
        set_hm(h, m); alarm_sel = 2'(sel); ld_alarm = 1'b1; step(); ld_alarm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_time = 0; ld_alarm = 0; stop_al = 0; snooze = 0;
        alarm_sel = 0; al_on = 4'b0000; set_hm(0, 0);
        @(negedge clk);
        run(3);
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_s_out0", 32'(s_out0), 0);
        reset = 1'b0;

        run(240);
        chk("min1_m_out0", 32'(m_out0), 1);
        chk("min1_s_out1", 32'(s_out1), 0);

        load_time(23, 59);
        run(12);
        chk("ld_s_out0", 32'(s_out0), 3);
        run(228);
        chk("wrap_m_out1", 32'(m_out1), 0);
        chk("wrap_m_out0", 32'(m_out0), 0);
        chk("wrap_s_out0", 32'(s_out0), 0);

        h_in1 = 2'd2; h_in0 = 4'd4; m_in1 = 4'd0; m_in0 = 4'd0;
        ld_time = 1'b1; step(); ld_time = 1'b0;
        chk("bad_ld_err", 32'(ld_err), 1);
        chk("bad_ld_m_out0", 32'(m_out0), 0);
        step();
        chk("ld_err_pulse", 32'(ld_err), 0);

        al_on = 4'b0100;
        load_alarm(2, 0, 2);
        load_time(0, 1);
        run(241);
        chk("slot2_alarm", 32'(alarm), 1);
        chk("slot2_id", 32'(alarm_id), 2);
        run(12);
        chk("slot2_timeout", 32'(alarm), 0);

        al_on = 4'b0010;
        load_alarm(1, 23, 58);
        load_time(23, 57);
        run(241);
        chk("slot1_alarm", 32'(alarm), 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        step();
        chk("snooze_quiet", 32'(alarm), 0);
        run(1198);
        chk("snooze_ring", 32'(alarm), 1);
        chk("snooze_id", 32'(alarm_id), 1);
        chk("snooze_m_out0", 32'(m_out0), 3);
        run(16);

        al_on = 4'b1001;
        load_alarm(0, 1, 0);
        load_alarm(3, 1, 0);
        load_time(0, 59);
        run(241);
        chk("dual_alarm", 32'(alarm), 1);
        chk("dual_id", 32'(alarm_id), 0);
        stop_al = 1'b1; snooze = 1'b1; step(); stop_al = 1'b0; snooze = 1'b0;
        step();
        chk("stop_quiet", 32'(alarm), 0);
        run(1300);
        chk("no_rering", 32'(alarm), 0);

        al_on = 4'b0001;
        load_alarm(0, 2, 0);
        load_time(1, 59);
        run(241);
        chk("reload_ring", 32'(alarm), 1);
        load_alarm(0, 5, 0);
        step();
        chk("reload_idle", 32'(alarm), 0);

        load_time(13, 5);
`ifdef HOUR12_EN
        chk("h12_h_out0", 32'(h_out0), 1);
        chk("h12_pm", 32'(pm), 1);
`endif
        load_time(0, 30);
        step();

        al_on = 4'b1111;
        for (int c = 0; c < 5000; c++) begin
            int t;
            ld_time  = ($urandom_range(0, 1499) == 0);
            ld_alarm = ($urandom_range(0, 39) == 0);
            snooze   = ($urandom_range(0, 149) == 0);
            stop_al  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 399) == 0) al_on = 4'($urandom);
            alarm_sel = 2'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                h_in1 = 2'($urandom); h_in0 = 4'($urandom);
                m_in1 = 4'($urandom); m_in0 = 4'($urandom);
            end else begin
                t = (m_sec / 60 + int'($urandom_range(0, 2))) % 1440;
                set_hm(t / 60, t % 60);
            end
            step();
        end
        ld_time = 0; ld_alarm = 0; snooze = 0; stop_al = 0;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
